// File: rtl/ir_nec_pkg.sv
// ---------------------------------------------------------------------------
// ir_nec_pkg
// Shared definitions for the NEC infrared decoder:
//   - FSM state enumeration
//   - pulse-width acceptance windows, in prescaler ticks (inclusive bounds)
//   - width-counter size and saturation value
//   - inWindow() helper used by the FSM to classify a measured width
// ---------------------------------------------------------------------------
package ir_nec_pkg;

  localparam int WIDTH_W = 8;
  localparam logic [WIDTH_W-1:0] WIDTH_SAT = 8'd255;

  // Leader mark (nominal 9 ms)
  localparam logic [WIDTH_W-1:0] LMARK_MIN  = 8'd160;
  localparam logic [WIDTH_W-1:0] LMARK_MAX  = 8'd200;
  // Leader space of a data frame (nominal 4.5 ms)
  localparam logic [WIDTH_W-1:0] LSPACE_MIN = 8'd80;
  localparam logic [WIDTH_W-1:0] LSPACE_MAX = 8'd100;
  // Leader space of a repeat code (nominal 2.25 ms)
  localparam logic [WIDTH_W-1:0] RSPACE_MIN = 8'd36;
  localparam logic [WIDTH_W-1:0] RSPACE_MAX = 8'd54;
  // Bit / stop mark (nominal 562 us)
  localparam logic [WIDTH_W-1:0] BMARK_MIN  = 8'd7;
  localparam logic [WIDTH_W-1:0] BMARK_MAX  = 8'd16;
  // Space encoding a logic 0 (nominal 562 us)
  localparam logic [WIDTH_W-1:0] SPACE0_MIN = 8'd7;
  localparam logic [WIDTH_W-1:0] SPACE0_MAX = 8'd16;
  // Space encoding a logic 1 (nominal 1.69 ms)
  localparam logic [WIDTH_W-1:0] SPACE1_MIN = 8'd27;
  localparam logic [WIDTH_W-1:0] SPACE1_MAX = 8'd40;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    REP_MARK
  } nec_state_e;

  function automatic logic inWindow(input logic [WIDTH_W-1:0] width,
                                    input logic [WIDTH_W-1:0] lo,
                                    input logic [WIDTH_W-1:0] hi);
    return (width >= lo) && (width <= hi);
  endfunction

endpackage

// File: rtl/ir_nec_rx_if.sv
// ---------------------------------------------------------------------------
// ir_nec_rx_if
// Decoded-code bus from the NEC decoder to its consumer (CPU PIO port).
//   code_valid  : one-cycle pulse, new frame or accepted repeat decoded
//   code_repeat : qualifies code_valid (1 = repeat code, 0 = new frame)
//   code_addr   : 16-bit address, bytes as received
//   code_cmd    : 8-bit command byte
//   code_err    : one-cycle pulse on a malformed or timed-out frame
//   busy        : decoder is in the middle of a frame
// Modports: master = decoder side (drives), slave = consumer side (reads).
// ---------------------------------------------------------------------------
interface ir_nec_rx_if;

  logic        code_valid;
  logic        code_repeat;
  logic [15:0] code_addr;
  logic [7:0]  code_cmd;
  logic        code_err;
  logic        busy;

  modport master (
    output code_valid,
    output code_repeat,
    output code_addr,
    output code_cmd,
    output code_err,
    output busy
  );

  modport slave (
    input code_valid,
    input code_repeat,
    input code_addr,
    input code_cmd,
    input code_err,
    input busy
  );

endinterface

// File: rtl/ir_edge_timer.sv
// ---------------------------------------------------------------------------
// ir_edge_timer
// Front end of the NEC decoder: brings the asynchronous IR pad into the clk
// domain, finds its edges and measures how long each phase lasted.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   i_irRx       : raw IR receiver output (idle high, mark low)
//   o_rise       : one-cycle pulse, line went high (mark ended)
//   o_fall       : one-cycle pulse, line went low (space ended)
//   o_width      : ticks elapsed in the phase that ended; valid with the edge
//   o_tick       : one-cycle prescaler pulse every TICK_DIV clocks
// Pad change to edge pulse is a fixed 3 clocks, so widths are unaffected.
// ---------------------------------------------------------------------------
module ir_edge_timer
  import ir_nec_pkg::*;
#(
  parameter int TICK_DIV = 1250
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_irRx,
  output logic               o_rise,
  output logic               o_fall,
  output logic [WIDTH_W-1:0] o_width,
  output logic               o_tick
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_syncPrev;
  logic               r_rise;
  logic               r_fall;
  logic [DIV_W-1:0]   r_div;
  logic               r_tick;
  logic [WIDTH_W-1:0] r_width;

  // Synchronizer and edge detector. Flops reset to the idle-high level so
  // leaving reset with the line idle produces no spurious edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_syncPrev <= 1'b1;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
    end else begin
      r_sync1    <= i_irRx;
      r_sync2    <= r_sync1;
      r_syncPrev <= r_sync2;
      r_rise     <= r_sync2 & ~r_syncPrev;
      r_fall     <= ~r_sync2 & r_syncPrev;
    end
  end

  // Free-running prescaler; the tick fires once per wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_div == DIV_LAST);
      if (r_div == DIV_LAST) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  // Width counter. It clears in the same cycle the edge pulse is presented,
  // so the consumer sees the finished phase length and the next phase
  // starts from zero. Saturation lets the FSM detect a stuck line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_width <= '0;
    end else if (r_rise || r_fall) begin
      r_width <= '0;
    end else if (r_tick && (r_width != WIDTH_SAT)) begin
      r_width <= r_width + 1'b1;
    end
  end

  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
  assign o_width = r_width;
  assign o_tick  = r_tick;

endmodule

// File: rtl/ir_nec_rx.sv
// ---------------------------------------------------------------------------
// ir_nec_rx
// NEC infrared protocol decoder. Turns the raw IR receiver line into decoded
// address/command words, a frame-valid pulse and a repeat flag.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   ir_rx        : raw IR receiver output (asynchronous, idle high)
//   o_code       : ir_nec_rx_if.master decoded-code bus
// Parameters:
//   CLK_HZ           : clock frequency in Hz
//   TICK_US          : width-measurement tick period in microseconds
//   REPEAT_WIN_TICKS : ticks after a good frame/repeat in which a repeat
//                      code is still accepted
// Build option:
//   IR_NEC_CHECK_EN  : when defined, a frame is only committed if the
//                      command-inverse byte matches ~command; otherwise it
//                      is reported as an error. The address is never checked.
// ---------------------------------------------------------------------------
module ir_nec_rx
  import ir_nec_pkg::*;
#(
  parameter int CLK_HZ           = 25000000,
  parameter int TICK_US          = 50,
  parameter int REPEAT_WIN_TICKS = 2400
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ir_rx,
  ir_nec_rx_if.master  o_code
);

  localparam int TICK_DIV = int'((longint'(CLK_HZ) * longint'(TICK_US)) / longint'(1000000));
  localparam int WIN_W    = $clog2(REPEAT_WIN_TICKS + 1);
  localparam logic [WIN_W-1:0] WIN_RELOAD = WIN_W'(REPEAT_WIN_TICKS);

  logic               w_rise;
  logic               w_fall;
  logic [WIDTH_W-1:0] w_width;
  logic               w_tick;

  nec_state_e         r_state;
  nec_state_e         w_nextState;
  logic               w_commitFrame;
  logic               w_commitRepeat;
  logic               w_err;
  logic               w_shiftEn;
  logic               w_shiftBit;
  logic               w_clrBitCnt;

  logic [31:0]        r_shift;
  logic [4:0]         r_bitCnt;
  logic [WIN_W-1:0]   r_window;
  logic               r_haveCode;

  logic               r_codeValid;
  logic               r_codeRepeat;
  logic [15:0]        r_codeAddr;
  logic [7:0]         r_codeCmd;
  logic               r_codeErr;

  ir_edge_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_edgeTimer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_irRx  (ir_rx),
    .o_rise  (w_rise),
    .o_fall  (w_fall),
    .o_width (w_width),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and control strobes. A saturated width outside IDLE is a
  // stuck line and takes priority over any edge in the same cycle.
  // A malformed repeat code is dropped silently because stray repeats
  // are common and carry no data worth flagging.
  always_comb begin
    w_nextState    = r_state;
    w_commitFrame  = 1'b0;
    w_commitRepeat = 1'b0;
    w_err          = 1'b0;
    w_shiftEn      = 1'b0;
    w_shiftBit     = 1'b0;
    w_clrBitCnt    = 1'b0;

    if ((r_state != IDLE) && (w_width == WIDTH_SAT)) begin
      w_err       = 1'b1;
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            w_nextState = LEAD_MARK;
          end
        end

        LEAD_MARK: begin
          if (w_rise) begin
            if (inWindow(w_width, LMARK_MIN, LMARK_MAX)) begin
              w_nextState = LEAD_SPACE;
            end else begin
              w_err       = 1'b1;
              w_nextState = IDLE;
            end
          end
        end

        LEAD_SPACE: begin
          if (w_fall) begin
            if (inWindow(w_width, LSPACE_MIN, LSPACE_MAX)) begin
              w_nextState = BIT_MARK;
              w_clrBitCnt = 1'b1;
            end else if (inWindow(w_width, RSPACE_MIN, RSPACE_MAX)) begin
              w_nextState = REP_MARK;
            end else begin
              w_err       = 1'b1;
              w_nextState = IDLE;
            end
          end
        end

        BIT_MARK: begin
          if (w_rise) begin
            if (inWindow(w_width, BMARK_MIN, BMARK_MAX)) begin
              w_nextState = BIT_SPACE;
            end else begin
              w_err       = 1'b1;
              w_nextState = IDLE;
            end
          end
        end

        BIT_SPACE: begin
          if (w_fall) begin
            if (inWindow(w_width, SPACE0_MIN, SPACE0_MAX) ||
                inWindow(w_width, SPACE1_MIN, SPACE1_MAX)) begin
              w_shiftEn   = 1'b1;
              w_shiftBit  = inWindow(w_width, SPACE1_MIN, SPACE1_MAX);
              w_nextState = (r_bitCnt == 5'd31) ? STOP_MARK : BIT_MARK;
            end else begin
              w_err       = 1'b1;
              w_nextState = IDLE;
            end
          end
        end

        STOP_MARK: begin
          if (w_rise) begin
            w_nextState = IDLE;
            if (inWindow(w_width, BMARK_MIN, BMARK_MAX)) begin
`ifdef IR_NEC_CHECK_EN
              if (r_shift[31:24] == ~r_shift[23:16]) begin
                w_commitFrame = 1'b1;
              end else begin
                w_err = 1'b1;
              end
`else
              w_commitFrame = 1'b1;
`endif
            end else begin
              w_err = 1'b1;
            end
          end
        end

        REP_MARK: begin
          if (w_rise) begin
            w_nextState = IDLE;
            if (inWindow(w_width, BMARK_MIN, BMARK_MAX) && r_haveCode &&
                (r_window != '0)) begin
              w_commitRepeat = 1'b1;
            end
          end
        end

        default: begin
          w_nextState = IDLE;
        end
      endcase
    end
  end

  // Bits arrive LSB first, so each new bit enters at the top and after 32
  // bits the first one received sits in bit 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift  <= '0;
      r_bitCnt <= '0;
    end else begin
      if (w_clrBitCnt) begin
        r_bitCnt <= '0;
      end else if (w_shiftEn) begin
        r_bitCnt <= r_bitCnt + 1'b1;
      end
      if (w_shiftEn) begin
        r_shift <= {w_shiftBit, r_shift[31:1]};
      end
    end
  end

  // Repeat-acceptance window. Any commit restarts it; once it runs out the
  // remembered code is forgotten so a late repeat cannot resurrect it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_window   <= '0;
      r_haveCode <= 1'b0;
    end else begin
      if (w_commitFrame || w_commitRepeat) begin
        r_window <= WIN_RELOAD;
      end else if (w_tick && (r_window != '0)) begin
        r_window <= r_window - 1'b1;
      end
      if (w_commitFrame) begin
        r_haveCode <= 1'b1;
      end else if (r_window == '0) begin
        r_haveCode <= 1'b0;
      end
    end
  end

  // Output registers. Data and the repeat flag hold until the next commit;
  // errors leave them untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_codeValid  <= 1'b0;
      r_codeRepeat <= 1'b0;
      r_codeAddr   <= '0;
      r_codeCmd    <= '0;
      r_codeErr    <= 1'b0;
    end else begin
      r_codeValid <= w_commitFrame | w_commitRepeat;
      r_codeErr   <= w_err;
      if (w_commitFrame) begin
        r_codeAddr   <= r_shift[15:0];
        r_codeCmd    <= r_shift[23:16];
        r_codeRepeat <= 1'b0;
      end else if (w_commitRepeat) begin
        r_codeRepeat <= 1'b1;
      end
    end
  end

  assign o_code.code_valid  = r_codeValid;
  assign o_code.code_repeat = r_codeRepeat;
  assign o_code.code_addr   = r_codeAddr;
  assign o_code.code_cmd    = r_codeCmd;
  assign o_code.code_err    = r_codeErr;
  assign o_code.busy        = (r_state != IDLE);

endmodule

// File: tb/tb_ir_nec_rx.sv
// ---------------------------------------------------------------------------
// tb_ir_nec_rx
// Testbench for ir_nec_rx. The clock rate parameter is scaled down so one
// tick is two clocks; all IR timing is expressed in ticks. A protocol-level
// model predicts which codes and errors each transmission must produce.
// ---------------------------------------------------------------------------
module tb_ir_nec_rx;

  localparam int CLK_HZ   = 40000;
  localparam int TICK_US  = 50;
  localparam int WIN      = 2400;
  localparam int TDIV     = (CLK_HZ * TICK_US) / 1000000;

  typedef struct {
    logic        rpt;
    logic [15:0] addr;
    logic [7:0]  cmd;
  } nec_evt_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic irRx    = 1'b1;

  int compared   = 0;
  int mismatched = 0;

  nec_evt_t obsQ[$];
  nec_evt_t expQ[$];
  int obsErr = 0;
  int expErr = 0;

  int          nowTicks   = 0;
  int          lastCommit = 0;
  bit          haveCode   = 1'b0;
  logic [15:0] lastAddr   = '0;
  logic [7:0]  lastCmd    = '0;
  bit          nominal    = 1'b1;

  ir_nec_rx_if codeBus ();

  ir_nec_rx #(
    .CLK_HZ           (CLK_HZ),
    .TICK_US          (TICK_US),
    .REPEAT_WIN_TICKS (WIN)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ir_rx   (irRx),
    .o_code  (codeBus)
  );

  always #5 clk = ~clk;

  // Collect everything the decoder reports, away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (codeBus.code_valid) begin
        nec_evt_t ev;
        ev.rpt  = codeBus.code_repeat;
        ev.addr = codeBus.code_addr;
        ev.cmd  = codeBus.code_cmd;
        obsQ.push_back(ev);
      end
      if (codeBus.code_err) begin
        obsErr++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic level, input int ticks);
    irRx = level;
    repeat (ticks * TDIV) @(negedge clk);
    nowTicks += ticks;
  endtask

  function automatic int pick(input int nomVal, input int lo, input int hi);
    if (nominal) return nomVal;
    return int'($urandom_range(hi, lo));
  endfunction

  // Protocol model: a well-formed frame is a new code unless the optional
  // inverse check rejects it.
  task automatic modelFrame(input logic [31:0] sr);
    nec_evt_t ev;
`ifdef IR_NEC_CHECK_EN
    if (sr[31:24] != ~sr[23:16]) begin
      expErr++;
      return;
    end
`endif
    ev.rpt  = 1'b0;
    ev.addr = sr[15:0];
    ev.cmd  = sr[23:16];
    expQ.push_back(ev);
    haveCode   = 1'b1;
    lastCommit = nowTicks;
    lastAddr   = sr[15:0];
    lastCmd    = sr[23:16];
  endtask

  // A repeat counts only inside the window after the last accepted code.
  task automatic modelRepeat();
    nec_evt_t ev;
    int elapsed;
    elapsed = nowTicks - lastCommit;
    if (haveCode && (elapsed < WIN)) begin
      ev.rpt  = 1'b1;
      ev.addr = lastAddr;
      ev.cmd  = lastCmd;
      expQ.push_back(ev);
      lastCommit = nowTicks;
    end else if (elapsed >= WIN) begin
      haveCode = 1'b0;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " valid"},  codeBus.code_valid,  0);
    checkOutput({tag, " repeat"}, codeBus.code_repeat, 0);
    checkOutput({tag, " addr"},   codeBus.code_addr,   0);
    checkOutput({tag, " cmd"},    codeBus.code_cmd,    0);
    checkOutput({tag, " err"},    codeBus.code_err,    0);
    checkOutput({tag, " busy"},   codeBus.busy,        0);
  endtask

  // mode 0: full frame; 1: reset pulsed during mark of abortBit;
  // 2: line stuck low from the mark of abortBit.
  task automatic sendFrame(input logic [31:0] sr, input int mode, input int abortBit);
    applyStimulus(1'b0, pick(180, 162, 198));
    applyStimulus(1'b1, pick(90, 82, 98));
    for (int b = 0; b < 32; b++) begin
      if ((mode != 0) && (b == abortBit)) begin
        if (mode == 1) begin
          applyStimulus(1'b0, 5);
          reset_n = 1'b0;
          irRx    = 1'b1;
          repeat (2) @(negedge clk);
          checkAllZero("midReset");
          haveCode = 1'b0;
          repeat (3) @(negedge clk);
          reset_n = 1'b1;
          applyStimulus(1'b1, 40);
        end else begin
          applyStimulus(1'b0, 100);
          checkOutput("busyMidStuck", codeBus.busy, 1);
          applyStimulus(1'b0, 170);
          expErr++;
          checkOutput("busyAfterTimeout", codeBus.busy, 0);
          checkOutput("errAtTimeout", obsErr, expErr);
          applyStimulus(1'b0, 130);
          applyStimulus(1'b1, 50);
        end
        return;
      end
      applyStimulus(1'b0, pick(11, 9, 14));
      applyStimulus(1'b1, sr[b] ? pick(34, 29, 38) : pick(11, 9, 14));
    end
    applyStimulus(1'b0, pick(11, 9, 14));
    modelFrame(sr);
    applyStimulus(1'b1, 20);
  endtask

  task automatic sendRepeat();
    applyStimulus(1'b0, pick(180, 162, 198));
    applyStimulus(1'b1, pick(45, 38, 52));
    applyStimulus(1'b0, pick(11, 9, 14));
    modelRepeat();
    applyStimulus(1'b1, 20);
  endtask

  task automatic checkScenario(input string tag);
    checkOutput({tag, " codeCount"}, obsQ.size(), expQ.size());
    while ((obsQ.size() > 0) && (expQ.size() > 0)) begin
      nec_evt_t o;
      nec_evt_t e;
      o = obsQ.pop_front();
      e = expQ.pop_front();
      checkOutput({tag, " repeat"}, o.rpt,  e.rpt);
      checkOutput({tag, " addr"},   o.addr, e.addr);
      checkOutput({tag, " cmd"},    o.cmd,  e.cmd);
    end
    obsQ.delete();
    expQ.delete();
    checkOutput({tag, " errCount"}, obsErr, expErr);
  endtask

  function automatic logic [31:0] randomFrame();
    logic [15:0] a;
    logic [7:0]  c;
    a = 16'($urandom);
    c = 8'($urandom);
    return {~c, c, a};
  endfunction

  initial begin
    $display("[TB] start, TICK_DIV=%0d", TDIV);
    repeat (4) @(negedge clk);
    checkAllZero("reset");
    reset_n = 1'b1;
    applyStimulus(1'b1, 50);

    nominal = 1'b1;
    sendFrame(32'hBA45FF00, 0, 0);
    checkScenario("nominalFrame");
    checkOutput("nominal addrOut",   codeBus.code_addr,   32'hFF00);
    checkOutput("nominal cmdOut",    codeBus.code_cmd,    32'h45);
    checkOutput("nominal repeatOut", codeBus.code_repeat, 0);

    applyStimulus(1'b1, 780);
    sendRepeat();
    checkScenario("repeat40ms");
    checkOutput("repeat40 repeatOut", codeBus.code_repeat, 1);
    checkOutput("repeat40 addrOut",   codeBus.code_addr,   32'hFF00);

    applyStimulus(1'b1, 4000);
    sendRepeat();
    checkScenario("repeat200ms");

    nominal = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    haveCode = 1'b0;
    reset_n  = 1'b1;
    applyStimulus(1'b1, 30);
    sendRepeat();
    checkScenario("repeatAfterReset");

    applyStimulus(1'b0, 140);
    expErr++;
    applyStimulus(1'b1, 300);
    checkScenario("shortLeader");
    checkOutput("shortLeader busy", codeBus.busy, 0);
    sendFrame(randomFrame(), 0, 0);
    checkScenario("afterShortLeader");

    sendFrame(randomFrame(), 2, 5);
    checkScenario("stuckLow");

    sendFrame({8'hBB, 8'h45, 16'h1234}, 0, 0);
    checkScenario("badInverse");

    sendFrame(randomFrame(), 1, 10);
    checkScenario("resetMidFrame");
    sendFrame(randomFrame(), 0, 0);
    applyStimulus(1'b1, int'($urandom_range(300, 100)));
    sendRepeat();
    checkScenario("afterMidReset");

    for (int i = 0; i < 3; i++) begin
      sendFrame(randomFrame(), 0, 0);
      if ((i % 2) == 0) begin
        applyStimulus(1'b1, int'($urandom_range(1400, 200)));
      end else begin
        applyStimulus(1'b1, int'($urandom_range(2700, 2600)));
      end
      sendRepeat();
      applyStimulus(1'b1, int'($urandom_range(800, 100)));
      sendRepeat();
      checkScenario($sformatf("random%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
